// File: rtl/cla_pkg.sv
// Shared definitions for the multiword CLA sequencer: FSM encoding and counter sizing.
package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cla_multiword_sequencer_cla.sv
// Purely combinational WIDTH-bit carry look-ahead adder shared by the sequencer.
module behave_4bit_carry_lookahead_adder_parameter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH-1:0] w_g, w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Each carry is expanded from g/p/Cin directly, so no carry depends on another.
  always_comb begin
    logic acc;
    w_c    = '0;
    w_c[0] = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      acc = Cin;
      for (int j = 0; j <= i; j++) acc = w_g[j] | (w_p[j] & acc);
      w_c[i+1] = acc;
    end
  end

  assign Sum  = w_p ^ w_c[WIDTH-1:0];
  assign Cout = w_c[WIDTH];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Wide add/subtract built by pushing WIDTH-bit words, LSW first, through one shared CLA.
module cla_multiword_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   Sub,
  input  logic [WIDTH*WORDS-1:0] A,
  input  logic [WIDTH*WORDS-1:0] B,
  input  logic                   C_in,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] S,
  output logic                   C_out,
  output logic                   OVF
);

  localparam int N  = WIDTH * WORDS;
  localparam int CW = clog2(WORDS);

  state_t           r_state;
  logic [N-1:0]     r_a_sh, r_b_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  behave_4bit_carry_lookahead_adder_parameter #(.WIDTH(WIDTH)) u_cla (
    .A    (r_a_sh[WIDTH-1:0]),
    .B    (r_b_sh[WIDTH-1:0]),
    .Cin  (r_carry),
    .Sum  (w_sum),
    .Cout (w_cout)
  );

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_cnt == CW'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      C_out   <= 1'b0;
      OVF     <= 1'b0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1; the forced carry replaces C_in.
      r_a_sh  <= A;
      r_b_sh  <= Sub ? ~B : B;
      r_carry <= Sub ? 1'b1 : C_in;
      r_cnt   <= '0;
      S       <= '0;
      C_out   <= 1'b0;
      OVF     <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          S       <= {w_sum, S[N-1:WIDTH]};
          r_a_sh  <= r_a_sh >> WIDTH;
          r_b_sh  <= r_b_sh >> WIDTH;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            C_out   <= w_cout;
            OVF     <= (r_a_sh[WIDTH-1] == r_b_sh[WIDTH-1]) && (w_sum[WIDTH-1] != r_a_sh[WIDTH-1]);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cla_multiword_sequencer.md
# cla_multiword_sequencer

- Performs wide add and subtract (WIDTH×WORDS bits) by time-multiplexing a single WIDTH-bit carry look-ahead adder instance, one word per clock, least-significant word first.
- A registered carry links consecutive words.
- It is the sequencing layer above the parameterized CLA: the CLA stays purely combinational, and this block owns operand staging, carry chaining, result assembly and the start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 8, bit width of the shared CLA word (≥ 2)
- WORDS, 4, number of words per operand (≥ 2); total operand width N = WIDTH*WORDS

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; asynchronous, active-high
- start  in  1  request pulse, sampled on the rising edge
- Sub  in  1  0 = A+B+C_in; 1 = A−B (C_in ignored)
- A  in  N  operand A, sampled with start
- B  in  N  operand B, sampled with start
- C_in  in  1  carry in for add, sampled with start
- busy  out  1  high while words are being processed
- done  out  1  one-cycle pulse when the result is valid
- S  out  N  result, held from done until the next accepted start
- C_out  out  1  final carry out; on subtract 1 = no borrow
- OVF  out  1  two's-complement overflow of the N-bit operation

## Operation
- States: IDLE, RUN, DONE.
- start is accepted in IDLE or DONE only. start in RUN is ignored and does not affect the operation in progress.
- On an accepted start:
  - Latch A into shift register a_sh.
  - Latch B, or ~B when Sub=1, into b_sh.
  - Load the carry register with C_in, or with 1 when Sub=1.
  - Clear the word counter. Clear S, C_out and OVF.
  - Go to RUN.
- Each RUN cycle:
  - The CLA sums a_sh[WIDTH-1:0], b_sh[WIDTH-1:0] and carry.
  - The sum word shifts into S from the top: S <= {sum, S[N-1:WIDTH]}.
  - a_sh and b_sh shift right by WIDTH. carry <= CLA Cout. Counter increments.
- On the RUN cycle where the counter equals WORDS−1:
  - C_out <= CLA Cout.
  - OVF <= (a_msb == b_msb) && (sum_msb != a_msb), using the MSBs of the final word's CLA inputs (b after inversion) and output.
  - Go to DONE.
- DONE lasts one cycle. Next state is RUN if start is high, else IDLE.
- Width rules:
  - All arithmetic is modulo 2^N.
  - No sign extension.
  - C_out is the carry out of bit N−1 only.
- Reset, at any time including mid-RUN:
  - State goes to IDLE; counter, carry, a_sh and b_sh are cleared.
  - busy=0, done=0, S=0, C_out=0, OVF=0.
  - A partially accumulated result is discarded; no done is issued.

## Timing
- Start is sampled at edge E0.
- busy is high in the cycles after E0 through E_WORDS; the CLA word k is processed at edge E(k+1).
- done is high for exactly one cycle after E_WORDS. Latency from start edge to done is WORDS cycles.
- S, C_out and OVF are stable and valid when done is high. They hold their values until the next accepted start, which clears them at that edge.
- Back-to-back operation: start held high during the DONE cycle begins the next operation. Throughput is one result per WORDS+1 cycles.
- All outputs are registered. The CLA path is one combinational stage between registers.

## Structure
- Shared package (cla_pkg) holds:
  - state encoding localparams: ST_IDLE, ST_RUN, ST_DONE
  - the counter-width function clog2(WORDS)
- One sub-module: the existing behave_4bit_carry_lookahead_adder_parameter #(WIDTH), instantiated once with ports A, B, Cin, Sum, Cout.
- No other hierarchy. The FSM, shift registers and flag logic live in this module.

## Test plan
All scenarios run with WIDTH=4, WORDS=2 (N=8) unless noted.
- A=8'hB7, B=8'hD0, C_in=0, Sub=0 → done 2 cycles after the start edge; S=8'h87, C_out=1, OVF=0. busy is high for exactly 2 cycles.
- A=8'h50, B=8'h30, Sub=1, C_in=1 → S=8'h20, C_out=1, OVF=0. This checks that C_in is ignored on subtract.
- A=8'h70, B=8'h10, Sub=0, C_in=0 → S=8'h80, C_out=0, OVF=1. A=8'h30, B=8'h50, Sub=1 → S=8'hE0, C_out=0 (borrow).
- A=8'hFF, B=8'h00, C_in=1 → S=8'h00, C_out=1. The carry must propagate across the word boundary.
- Handshake:
  - start pulsed during RUN is ignored and the result is unchanged.
  - start held during DONE starts the next operation immediately, with no IDLE cycle.
- Reset asserted asynchronously in the middle of the first RUN cycle → all outputs 0 immediately, no done pulse. A following start runs correctly.
- Scaling: with WIDTH=8, WORDS=4, run 200 random A/B/Sub/C_in → S, C_out and OVF match a reference 32-bit model.
